// File: rtl/gpio_cfg_pkg.sv
// Shared constants, FSM state type and address helpers for the GPIO
// configuration shift-chain sequencer.
package gpio_cfg_pkg;

  localparam int unsigned NBLK = 19;
  localparam int unsigned WORD = 13;

  localparam logic [5:0] CH1_BASE = 6'd18;
  localparam logic [5:0] CH2_BASE = 6'd19;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SHIFT_LO = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_LOAD_LO  = 3'd3,
    ST_LOAD_HI  = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  // Bit positions inside the housekeeping bit-bang register
  localparam int unsigned BB_XFER_BIT   = 0;
  localparam int unsigned BB_ENABLE_BIT = 1;
  localparam int unsigned BB_RESETN_BIT = 2;
  localparam int unsigned BB_LOAD_BIT   = 3;
  localparam int unsigned BB_CLOCK_BIT  = 4;
  localparam int unsigned BB_DATA1_BIT  = 5;
  localparam int unsigned BB_DATA2_BIT  = 6;

  // Chain 1 walks GPIO 18 down to 0, chain 2 walks GPIO 19 up to 37
  function automatic logic [5:0] ch1_addr(input logic [4:0] blk);
    return CH1_BASE - {1'b0, blk};
  endfunction

  function automatic logic [5:0] ch2_addr(input logic [4:0] blk);
    return CH2_BASE + {1'b0, blk};
  endfunction

endpackage

// File: rtl/gpio_serial_clkdiv.sv
// Half-period down-counter: while running, emits a one-cycle tick every
// CLK_DIV cycles and reloads, so each FSM state lasts exactly CLK_DIV cycles.
module gpio_serial_clkdiv #(
  parameter logic [7:0] CLK_DIV = 8'd4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  output logic tick_o
);

  localparam logic [7:0] RELOAD = CLK_DIV - 8'd1;

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: reload when idle or on expiry, otherwise count down
  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || (cnt_q == 8'd0)) begin
      cnt_d = RELOAD;
    end else begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = run_i && (cnt_q == 8'd0);

endmodule

// File: rtl/gpio_serial_loader.sv
// Sequencer that shifts all pad configuration words into the two GPIO
// shift chains and pulses load, or passes the bit-bang register through.
module gpio_serial_loader
  import gpio_cfg_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rstn_i,
  input  logic        xfer_start,
  output logic        xfer_busy,
  output logic        xfer_done,
  output logic [5:0]  cfg_addr_1,
  input  logic [12:0] cfg_data_1,
  output logic [5:0]  cfg_addr_2,
  input  logic [12:0] cfg_data_2,
  input  logic        bb_en,
  input  logic        bb_resetn,
  input  logic        bb_load,
  input  logic        bb_clock,
  input  logic        bb_data_1,
  input  logic        bb_data_2,
  output logic        serial_resetn,
  output logic        serial_load,
  output logic        serial_clock,
  output logic        serial_data_1,
  output logic        serial_data_2
);

  localparam logic [3:0] BIT_MSB  = 4'(WORD - 1);
  localparam logic [4:0] BLK_LAST = 5'(NBLK - 1);

  state_e      state_q;
  logic [4:0]  blk_q;
  logic [3:0]  bit_q;
  logic        busy_q;
  logic        done_q;
  logic        resetn_q;
  logic        load_q;
  logic        sclk_q;
  logic        sd1_q;
  logic        sd2_q;
  logic [5:0]  addr1_q;
  logic [5:0]  addr2_q;
  logic        tick_s;

  gpio_serial_clkdiv #(
    .CLK_DIV (8'(CLK_DIV))
  ) u_clkdiv (
    .clk_i  (wb_clk_i),
    .rst_ni (wb_rstn_i),
    .run_i  (busy_q),
    .tick_o (tick_s)
  );

  // Sequencer FSM with registered chain outputs. The regfile address runs one
  // block ahead during the last SHIFT_HI of a word, so the next word's MSB is
  // already readable on the edge that enters its first SHIFT_LO.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_q  <= ST_IDLE;
      blk_q    <= 5'd0;
      bit_q    <= BIT_MSB;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      resetn_q <= 1'b0;
      load_q   <= 1'b0;
      sclk_q   <= 1'b0;
      sd1_q    <= 1'b0;
      sd2_q    <= 1'b0;
      addr1_q  <= CH1_BASE;
      addr2_q  <= CH2_BASE;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          blk_q <= 5'd0;
          bit_q <= BIT_MSB;
          if (bb_en) begin
            resetn_q <= bb_resetn;
            load_q   <= bb_load;
            sclk_q   <= bb_clock;
            sd1_q    <= bb_data_1;
            sd2_q    <= bb_data_2;
          end else if (xfer_start) begin
            state_q  <= ST_SHIFT_LO;
            busy_q   <= 1'b1;
            resetn_q <= 1'b1;
            load_q   <= 1'b0;
            sclk_q   <= 1'b0;
            sd1_q    <= cfg_data_1[BIT_MSB];
            sd2_q    <= cfg_data_2[BIT_MSB];
          end else begin
            resetn_q <= 1'b1;
            load_q   <= 1'b0;
            sclk_q   <= 1'b0;
            sd1_q    <= 1'b0;
            sd2_q    <= 1'b0;
          end
        end
        ST_SHIFT_LO: begin
          sd1_q <= cfg_data_1[bit_q];
          sd2_q <= cfg_data_2[bit_q];
          if (tick_s) begin
            state_q <= ST_SHIFT_HI;
            sclk_q  <= 1'b1;
            if ((bit_q == 4'd0) && (blk_q != BLK_LAST)) begin
              addr1_q <= ch1_addr(blk_q + 5'd1);
              addr2_q <= ch2_addr(blk_q + 5'd1);
            end
          end
        end
        ST_SHIFT_HI: begin
          if (tick_s) begin
            sclk_q <= 1'b0;
            if (bit_q == 4'd0) begin
              if (blk_q == BLK_LAST) begin
                state_q <= ST_LOAD_LO;
                sd1_q   <= 1'b0;
                sd2_q   <= 1'b0;
                addr1_q <= CH1_BASE;
                addr2_q <= CH2_BASE;
              end else begin
                state_q <= ST_SHIFT_LO;
                blk_q   <= blk_q + 5'd1;
                bit_q   <= BIT_MSB;
                sd1_q   <= cfg_data_1[BIT_MSB];
                sd2_q   <= cfg_data_2[BIT_MSB];
              end
            end else begin
              state_q <= ST_SHIFT_LO;
              bit_q   <= bit_q - 4'd1;
              sd1_q   <= cfg_data_1[bit_q - 4'd1];
              sd2_q   <= cfg_data_2[bit_q - 4'd1];
            end
          end
        end
        ST_LOAD_LO: begin
          if (tick_s) begin
            state_q <= ST_LOAD_HI;
            load_q  <= 1'b1;
          end
        end
        ST_LOAD_HI: begin
          if (tick_s) begin
            state_q <= ST_DONE;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q  <= ST_IDLE;
          busy_q   <= 1'b0;
          resetn_q <= 1'b1;
          load_q   <= 1'b0;
          sclk_q   <= 1'b0;
          sd1_q    <= 1'b0;
          sd2_q    <= 1'b0;
          addr1_q  <= CH1_BASE;
          addr2_q  <= CH2_BASE;
        end
      endcase
    end
  end

  assign xfer_busy     = busy_q;
  assign xfer_done     = done_q;
  assign cfg_addr_1    = addr1_q;
  assign cfg_addr_2    = addr2_q;
  assign serial_resetn = resetn_q;
  assign serial_load   = load_q;
  assign serial_clock  = sclk_q;
  assign serial_data_1 = sd1_q;
  assign serial_data_2 = sd2_q;

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Self-checking bench: bit-bang vector table, full transfers checked against
// a chain model, arbitration, mid-transfer reset and a CLK_DIV=1 instance.
module tb_gpio_serial_loader;

  logic clk = 1'b0;
  logic rst_n;
  logic xfer_start, start1;
  logic bb_en, bb_resetn, bb_load, bb_clock, bb_data_1, bb_data_2;
  logic busy, done, sresetn, sload, sclock, sd1, sd2;
  logic [5:0] addr1, addr2;
  logic [12:0] data1, data2;
  logic u1_busy, u1_done, u1_rn, u1_ld, u1_ck, u1_d1, u1_d2;
  logic [5:0] u1_a1, u1_a2;
  logic [12:0] u1_data1, u1_data2;

  logic [12:0] regs [0:63];
  assign data1    = regs[addr1];
  assign data2    = regs[addr2];
  assign u1_data1 = regs[u1_a1];
  assign u1_data2 = regs[u1_a2];

  always #5 clk = ~clk;

  gpio_serial_loader #(.CLK_DIV(4)) dut (
    .wb_clk_i(clk), .wb_rstn_i(rst_n), .xfer_start(xfer_start),
    .xfer_busy(busy), .xfer_done(done),
    .cfg_addr_1(addr1), .cfg_data_1(data1), .cfg_addr_2(addr2), .cfg_data_2(data2),
    .bb_en(bb_en), .bb_resetn(bb_resetn), .bb_load(bb_load), .bb_clock(bb_clock),
    .bb_data_1(bb_data_1), .bb_data_2(bb_data_2),
    .serial_resetn(sresetn), .serial_load(sload), .serial_clock(sclock),
    .serial_data_1(sd1), .serial_data_2(sd2));

  gpio_serial_loader #(.CLK_DIV(1)) dut1 (
    .wb_clk_i(clk), .wb_rstn_i(rst_n), .xfer_start(start1),
    .xfer_busy(u1_busy), .xfer_done(u1_done),
    .cfg_addr_1(u1_a1), .cfg_data_1(u1_data1), .cfg_addr_2(u1_a2), .cfg_data_2(u1_data2),
    .bb_en(bb_en), .bb_resetn(bb_resetn), .bb_load(bb_load), .bb_clock(bb_clock),
    .bb_data_1(bb_data_1), .bb_data_2(bb_data_2),
    .serial_resetn(u1_rn), .serial_load(u1_ld), .serial_clock(u1_ck),
    .serial_data_1(u1_d1), .serial_data_2(u1_d2));

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Chain model / event counters for the CLK_DIV=4 instance
  bit q1 [$];
  bit q2 [$];
  int rises, busy_cyc, load_cyc, done_cnt, rst_viol;
  logic prev_sclk = 1'b0;
  // Counters for the CLK_DIV=1 instance
  int u1_rises, u1_busy_cyc, u1_tog_viol;
  logic u1_prev_ck = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (sclock && !prev_sclk) begin
      q1.push_back(sd1);
      q2.push_back(sd2);
      rises++;
    end
    prev_sclk = sclock;
    if (busy) busy_cyc++;
    if (busy && !sresetn) rst_viol++;
    if (sload) load_cyc++;
    if (done) done_cnt++;
    if (u1_ck && !u1_prev_ck) u1_rises++;
    u1_prev_ck = u1_ck;
    if (u1_busy) begin
      if (u1_busy_cyc < 494 && u1_ck !== 1'(u1_busy_cyc % 2)) u1_tog_viol++;
      u1_busy_cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    q1.delete();
    q2.delete();
    rises = 0; busy_cyc = 0; load_cyc = 0; done_cnt = 0; rst_viol = 0;
  endtask

  // One full transfer on the CLK_DIV=4 instance, checked against the regfile
  task automatic run_xfer(input string tag, input bit disturb);
    logic [12:0] exp1 [0:18];
    logic [12:0] exp2 [0:18];
    logic [12:0] w1, w2;
    int t0, dt, n, bad1, bad2;
    bit got;
    for (int k = 0; k < 19; k++) begin
      exp1[k] = regs[18 - k];
      exp2[k] = regs[19 + k];
    end
    @(negedge clk); #1;
    clear_mon();
    xfer_start = 1'b1;
    t0 = cyc;
    @(negedge clk); #1;
    xfer_start = 1'b0;
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    n = 0; got = 1'b0; dt = 0;
    while (n < 5000 && !got) begin
      @(negedge clk); #1;
      n++;
      if (done) begin
        got = 1'b1;
        dt = cyc - t0;
      end
      if (disturb && n == 500) begin
        bb_en = 1'b1; bb_resetn = 1'b0; bb_load = 1'b1; bb_clock = 1'b1;
        bb_data_1 = 1'b1; bb_data_2 = 1'b1; xfer_start = 1'b1;
      end
      if (disturb && n == 501) xfer_start = 1'b0;
      if (disturb && n == 1200) begin
        bb_en = 1'b0; bb_resetn = 1'b0; bb_load = 1'b0; bb_clock = 1'b0;
        bb_data_1 = 1'b0; bb_data_2 = 1'b0;
      end
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_done_delay"}, 32'(dt), 32'd1985);
    repeat (3) @(negedge clk);
    #1;
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_clock_rises"}, 32'(rises), 32'd247);
    check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'd1984);
    check({tag, "_load_cycles"}, 32'(load_cyc), 32'd4);
    check({tag, "_resetn_low_busy"}, 32'(rst_viol), 32'd0);
    check({tag, "_idle_after"}, 32'(busy), 32'd0);
    check({tag, "_addr1_home"}, 32'(addr1), 32'd18);
    check({tag, "_addr2_home"}, 32'(addr2), 32'd19);
    bad1 = 0; bad2 = 0;
    if (q1.size() == 247 && q2.size() == 247) begin
      for (int k = 0; k < 19; k++) begin
        w1 = 13'd0; w2 = 13'd0;
        for (int b = 0; b < 13; b++) begin
          w1 = {w1[11:0], q1[k * 13 + b]};
          w2 = {w2[11:0], q2[k * 13 + b]};
        end
        if (w1 !== exp1[k]) bad1++;
        if (w2 !== exp2[k]) bad2++;
      end
    end else begin
      bad1 = 99; bad2 = 99;
    end
    check({tag, "_chain1_bad_blocks"}, 32'(bad1), 32'd0);
    check({tag, "_chain2_bad_blocks"}, 32'(bad2), 32'd0);
  endtask

  typedef struct {
    logic en, rn, ld, ck, d1, d2, st;
    logic e_rn, e_ld, e_ck, e_d1, e_d2;
  } bb_vec_t;

  initial begin
    bb_vec_t vecs [7];
    logic [5:0] r;
    int n, dc;
    bit got;

    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; xfer_start = 1'b0; start1 = 1'b0;
    bb_en = 1'b0; bb_resetn = 1'b0; bb_load = 1'b0; bb_clock = 1'b0;
    bb_data_1 = 1'b0; bb_data_2 = 1'b0;
    for (int i = 0; i < 64; i++) regs[i] = 13'd0;
    clear_mon();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_serial_resetn", 32'(sresetn), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_outputs", {28'd0, sload, sclock, sd1, sd2}, 32'd0);
    check("rst_addr1", 32'(addr1), 32'd18);
    check("rst_addr2", 32'(addr2), 32'd19);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_resetn", 32'(sresetn), 32'd1);

    // Bit-bang vector table
    for (int i = 0; i < 7; i++) begin
      bb_en = vecs[i].en; bb_resetn = vecs[i].rn; bb_load = vecs[i].ld;
      bb_clock = vecs[i].ck; bb_data_1 = vecs[i].d1; bb_data_2 = vecs[i].d2;
      xfer_start = vecs[i].st;
      @(negedge clk);
      check($sformatf("bb_vec%0d_outs", i), {27'd0, sresetn, sload, sclock, sd1, sd2},
            {27'd0, vecs[i].e_rn, vecs[i].e_ld, vecs[i].e_ck, vecs[i].e_d1, vecs[i].e_d2});
      check($sformatf("bb_vec%0d_busy", i), 32'(busy), 32'd0);
    end
    xfer_start = 1'b0;

    // Randomized bit-bang passthrough, xfer_start toggling and ignored
    clear_mon();
    for (int i = 0; i < 40; i++) begin
      r = 6'($urandom);
      bb_en = 1'b1;
      {bb_resetn, bb_load, bb_clock, bb_data_1, bb_data_2, xfer_start} = r;
      @(negedge clk);
      check($sformatf("bb_rand%0d", i), {27'd0, sresetn, sload, sclock, sd1, sd2},
            {27'd0, r[5:1]});
      check($sformatf("bb_rand%0d_busy", i), 32'(busy), 32'd0);
    end
    xfer_start = 1'b0; bb_en = 1'b0;
    {bb_resetn, bb_load, bb_clock, bb_data_1, bb_data_2} = 5'd0;
    repeat (2) @(negedge clk);
    check("bb_no_done", 32'(done_cnt), 32'd0);

    // Basic transfer with 0x1809 everywhere
    for (int i = 0; i < 64; i++) regs[i] = 13'h1809;
    run_xfer("basic", 1'b0);
    if (q1.size() >= 3) begin
      check("basic_first_bits", {29'd0, q1[0], q1[1], q1[2]}, 32'd6);
    end else begin
      check("basic_first_bits_count", 32'(q1.size()), 32'd247);
    end

    // Ordering with distinct words
    for (int i = 0; i < 64; i++) regs[i] = 13'((i * 32'h111) & 32'h1FFF);
    run_xfer("order", 1'b0);

    // Random words with bit-bang and a second start while busy
    for (int i = 0; i < 64; i++) regs[i] = 13'($urandom);
    run_xfer("arb", 1'b1);

    // Reset at bit 100
    for (int i = 0; i < 64; i++) regs[i] = 13'($urandom);
    @(negedge clk); #1;
    clear_mon();
    xfer_start = 1'b1;
    @(negedge clk); #1;
    xfer_start = 1'b0;
    n = 0;
    while (n < 3000 && rises < 100) begin
      @(negedge clk); #1;
      n++;
    end
    check("midrst_reached_bit100", 32'(rises >= 100), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_resetn", 32'(sresetn), 32'd0);
    check("midrst_outputs", {27'd0, busy, sload, sclock, sd1, sd2}, 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    dc = done_cnt;
    repeat (3) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt), 32'(dc));
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_release_resetn", 32'(sresetn), 32'd1);
    run_xfer("fresh", 1'b0);

    // CLK_DIV=1 instance
    for (int i = 0; i < 64; i++) regs[i] = 13'($urandom);
    @(negedge clk); #1;
    u1_rises = 0; u1_busy_cyc = 0; u1_tog_viol = 0;
    start1 = 1'b1;
    dc = cyc;
    @(negedge clk); #1;
    start1 = 1'b0;
    n = 0; got = 1'b0;
    while (n < 2000 && !got) begin
      @(negedge clk); #1;
      n++;
      if (u1_done) got = 1'b1;
    end
    check("div1_done_seen", 32'(got), 32'd1);
    check("div1_done_delay", 32'(cyc - dc), 32'd497);
    check("div1_busy_cycles", 32'(u1_busy_cyc), 32'd496);
    check("div1_clock_rises", 32'(u1_rises), 32'd247);
    check("div1_toggle_viol", 32'(u1_tog_viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
